fp_align_seq: RTL and testbench

//  Sequential pre-add alignment stage for the IEEE-754 single-precision adder; the input-side counterpart of the

---
 rtl/fp_align_seq.sv | 186 ++++++++++++++++++
 tb/tb_fp_align_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_align_seq.sv
// Pre-add alignment for single-precision add: unpack, order by exponent, shift smaller significand right with sticky.
// Latency: 2 cycles from accept to out_valid when no shift is needed, else 2 + ceil(diff/STEP) cycles.
// Backpressure: result held stable in DONE until out_ready; in_ready is high only in IDLE, so one operation in flight.
module fp_align_seq #(
    parameter int STEP   = 1,
    parameter int MAX_SH = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  exp_max,
    output logic        sign_big,
    output logic        sign_small,
    output logic [23:0] frac_big,
    output logic [23:0] frac_small,
    output logic        sticky,
    output logic        swap,
    output logic        special
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMP   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [8:0] MAX_SH_W = 9'(MAX_SH);
    localparam logic [4:0] STEP_W   = 5'(STEP);

    state_t      state;
    state_t      state_nxt;

    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [4:0]  cnt;

    // unpacked view of the latched operands
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [23:0] ma;
    logic [23:0] mb;
    logic        a_big;
    logic [7:0]  e_big;
    logic [23:0] m_big;
    logic [23:0] m_small;
    logic [8:0]  diff;
    logic        is_special;
    logic        no_shift;
    logic        far_shift;

    // per-cycle shift step
    logic [4:0]  step_amt;
    logic [23:0] lost_mask;

    // Unpack operands and pick the larger-exponent one; ties keep a as the big operand.
    always_comb begin
        ea         = (a_r[30:23] == 8'd0) ? 8'd1 : a_r[30:23];
        eb         = (b_r[30:23] == 8'd0) ? 8'd1 : b_r[30:23];
        ma         = {(a_r[30:23] != 8'd0), a_r[22:0]};
        mb         = {(b_r[30:23] != 8'd0), b_r[22:0]};
        a_big      = (ea >= eb);
        e_big      = a_big ? ea : eb;
        m_big      = a_big ? ma : mb;
        m_small    = a_big ? mb : ma;
        diff       = a_big ? ({1'b0, ea} - {1'b0, eb}) : ({1'b0, eb} - {1'b0, ea});
        is_special = (&a_r[30:23]) | (&b_r[30:23]);
        no_shift   = is_special | (diff == 9'd0);
        far_shift  = (diff >= MAX_SH_W);
    end

    // Shift amount this cycle is min(STEP, remaining); mask selects the bits falling off the bottom.
    always_comb begin
        step_amt  = (cnt < STEP_W) ? cnt : STEP_W;
        lost_mask = ~(24'hFF_FFFF << step_amt);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = CMP;
                end
            end
            CMP: begin
                if (no_shift || far_shift) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == step_amt) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are pure functions of state
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Operand capture on accept; later changes on a/b are not seen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= 32'd0;
            b_r <= 32'd0;
        end else if (state == IDLE && in_valid) begin
            a_r <= a;
            b_r <= b;
        end
    end

    // Result datapath: loaded in CMP, shifted in SHIFT, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_max    <= 8'd0;
            sign_big   <= 1'b0;
            sign_small <= 1'b0;
            frac_big   <= 24'd0;
            frac_small <= 24'd0;
            sticky     <= 1'b0;
            swap       <= 1'b0;
            special    <= 1'b0;
            cnt        <= 5'd0;
        end else begin
            case (state)
                CMP: begin
                    exp_max    <= e_big - 8'd127;
                    sign_big   <= a_big ? a_r[31] : b_r[31];
                    sign_small <= a_big ? b_r[31] : a_r[31];
                    frac_big   <= m_big;
                    swap       <= ~a_big;
                    special    <= is_special;
                    if (no_shift) begin
                        frac_small <= m_small;
                        sticky     <= 1'b0;
                        cnt        <= 5'd0;
                    end else if (far_shift) begin
                        // everything falls off: only the sticky survives
                        frac_small <= 24'd0;
                        sticky     <= |m_small;
                        cnt        <= 5'd0;
                    end else begin
                        frac_small <= m_small;
                        sticky     <= 1'b0;
                        cnt        <= diff[4:0];
                    end
                end
                SHIFT: begin
                    frac_small <= frac_small >> step_amt;
                    sticky     <= sticky | (|(frac_small & lost_mask));
                    cnt        <= cnt - step_amt;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_align_seq.sv
// Bench for fp_align_seq (STEP=1): scoreboard of expected results and latencies, checked as each result appears.
// Covers reset, aligned/unaligned/far operands, backpressure, async reset mid-shift, Inf/NaN and random traffic.
module tb_fp_align_seq;

    typedef struct packed {
        logic [7:0]  exp_max;
        logic        sign_big;
        logic        sign_small;
        logic [23:0] frac_big;
        logic [23:0] frac_small;
        logic        sticky;
        logic        swap;
        logic        special;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  exp_max;
    logic        sign_big;
    logic        sign_small;
    logic [23:0] frac_big;
    logic [23:0] frac_small;
    logic        sticky;
    logic        swap;
    logic        special;

    res_t obs;
    assign obs = {exp_max, sign_big, sign_small, frac_big, frac_small, sticky, swap, special};

    res_t res_q[$];
    int   lat_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    fp_align_seq #(.STEP(1), .MAX_SH(26)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .exp_max    (exp_max),
        .sign_big   (sign_big),
        .sign_small (sign_small),
        .frac_big   (frac_big),
        .frac_small (frac_small),
        .sticky     (sticky),
        .swap       (swap),
        .special    (special)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: shift one bit at a time, independent of the step size
    function automatic res_t model(input logic [31:0] av, input logic [31:0] bv, output int lat);
        res_t        r;
        logic [7:0]  ea, eb, ebig, esml;
        logic [23:0] ma, mb, fs;
        logic        st;
        int          d;
        ea = (av[30:23] == 8'd0) ? 8'd1 : av[30:23];
        eb = (bv[30:23] == 8'd0) ? 8'd1 : bv[30:23];
        ma = {(av[30:23] != 8'd0), av[22:0]};
        mb = {(bv[30:23] != 8'd0), bv[22:0]};
        r = '0;
        if (eb > ea) begin
            r.swap = 1'b1; ebig = eb; esml = ea;
            r.sign_big = bv[31]; r.sign_small = av[31]; r.frac_big = mb; fs = ma;
        end else begin
            r.swap = 1'b0; ebig = ea; esml = eb;
            r.sign_big = av[31]; r.sign_small = bv[31]; r.frac_big = ma; fs = mb;
        end
        d = int'(ebig) - int'(esml);
        st = 1'b0;
        if (d >= 26) begin
            st = |fs;
            fs = 24'd0;
        end else begin
            for (int i = 0; i < d; i++) begin
                st = st | fs[0];
                fs = fs >> 1;
            end
        end
        r.frac_small = fs;
        r.sticky     = st;
        r.exp_max    = ebig - 8'd127;
        r.special    = (av[30:23] == 8'hFF) || (bv[30:23] == 8'hFF);
        lat = (r.special || d == 0 || d >= 26) ? 2 : 2 + d;
        return r;
    endfunction

    // Issue one operation, wait for its result, compare, hold it for 'stall' cycles, then release.
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input int stall, input string name);
        res_t e;
        int   el;
        int   lat;
        e = model(av, bv, el);
        res_q.push_back(e);
        lat_q.push_back(el);
        out_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
        end
        a = av; b = bv; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e  = res_q.pop_front();
        el = lat_q.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s timeout: out_valid never rose within %0d cycles", name, lat);
            return;
        end
        n_cmp++;
        if (lat != el) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, el);
        end
        n_cmp++;
        if (e.special) begin
            if (obs.special !== 1'b1) begin
                n_fail++;
                $display("FAIL %s special: got %b want 1", name, obs.special);
            end
        end else if (obs !== e) begin
            n_fail++;
            $display("FAIL %s result: got exp=%h sb=%b ss=%b fb=%h fs=%h st=%b sw=%b sp=%b want exp=%h sb=%b ss=%b fb=%h fs=%h st=%b sw=%b sp=%b",
                     name, obs.exp_max, obs.sign_big, obs.sign_small, obs.frac_big, obs.frac_small, obs.sticky, obs.swap, obs.special,
                     e.exp_max, e.sign_big, e.sign_small, e.frac_big, e.frac_small, e.sticky, e.swap, e.special);
        end
        // backpressure: result must hold and a new request must be ignored
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            a = 32'h4000_0000; b = 32'h3F80_0000;
            @(posedge clk);
            #1;
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || (!e.special && obs !== e)) begin
                n_fail++;
                $display("FAIL %s hold cycle %0d: got vld=%b rdy=%b fs=%h want vld=1 rdy=0 fs=%h",
                         name, i, out_valid, in_ready, obs.frac_small, e.frac_small);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s release: got vld=%b rdy=%b want vld=0 rdy=1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || obs !== '0) begin
            n_fail++;
            $display("FAIL reset state: got rdy=%b vld=%b data=%h want rdy=1 vld=0 data=0", in_ready, out_valid, obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        do_op(32'h3F80_0000, 32'h4000_0000, 0, "swap_diff1");
        do_op(32'h3FC0_0000, 32'h3F80_0000, 0, "equal_exp");
        do_op(32'h4080_0000, 32'h3F80_0001, 0, "diff2_sticky");
        do_op(32'h4E80_0000, 32'h3F80_0001, 0, "diff30_far");
        do_op(32'h0000_0001, 32'h0080_0000, 0, "denormal");
        do_op(32'hC100_0000, 32'h3F80_0003, 0, "signs");
    endtask

    task automatic test_backpressure();
        do_op(32'h4080_0000, 32'h3F80_0001, 5, "stall5");
        do_op(32'h3FC0_0000, 32'h3F80_0000, 0, "after_stall");
    endtask

    task automatic test_reset_mid_shift();
        @(negedge clk);
        a = 32'h4980_0000; b = 32'h3F80_0000; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== '0) begin
            n_fail++;
            $display("FAIL mid_shift_reset: got vld=%b rdy=%b data=%h want vld=0 rdy=1 data=0", out_valid, in_ready, obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32'h7F80_0000, 32'h3F80_0000, 0, "special_inf");
        do_op(32'h3F80_0000, 32'h7FC0_0000, 0, "special_nan");
    endtask

    task automatic test_back_to_back();
        logic [31:0] av, bv;
        for (int i = 0; i < 24; i++) begin
            av = $urandom; bv = $urandom;
            av[30:23] = 8'($urandom_range(100, 140));
            bv[30:23] = 8'($urandom_range(100, 140));
            if (i % 7 == 3) bv[30:23] = 8'd0;
            do_op(av, bv, int'($urandom_range(0, 2)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
